// File: rtl/gpio_pkg.sv
// Shared register map for the GPIO bank.
// Register index occupies addr[2:0]; port select occupies addr[4:3].
package gpio_pkg;

    typedef enum logic [2:0] {
        REG_OUT  = 3'd0,
        REG_DIR  = 3'd1,
        REG_SET  = 3'd2,
        REG_CLR  = 3'd3,
        REG_IN   = 3'd4,
        REG_EDGE = 3'd5,
        REG_MASK = 3'd6,
        REG_RSVD = 3'd7
    } gpio_reg_e;

    localparam int unsigned BUS_W = 16;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop pad synchroniser with a rising-edge pulse on the synchronised value.
module gpio_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            meta   <= '0;
            stable <= '0;
            prev   <= '0;
        end else begin
            meta   <= pin;
            stable <= meta;
            prev   <= stable;
        end
    end

    assign sync = stable;
    assign rise = stable & ~prev;

endmodule

// File: rtl/gpio_bank.sv
// Multi-port GPIO register bank with pad synchronisers.
// Define GPIO_BANK_IRQ_EN to build EDGE/MASK capture and the irq output.
module gpio_bank #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PORTS = 3
) (
    input  logic                   clk,
    input  logic                   resetq,
    input  logic                   io_wr,
    input  logic                   io_rd,
    input  logic [4:0]             addr,
    input  logic [15:0]            wd,
    output logic [15:0]            rd,
    input  logic [PORTS*WIDTH-1:0] pin_in,
    output logic [PORTS*WIDTH-1:0] pin_out,
    output logic [PORTS*WIDTH-1:0] pin_oe,
    output logic                   irq
);
    import gpio_pkg::*;

    typedef logic [WIDTH-1:0] word_t;

    word_t     out_r  [PORTS];
    word_t     dir_r  [PORTS];
    word_t     in_s   [PORTS];
    word_t     rise_s [PORTS];
    logic [1:0] a_port;
    gpio_reg_e a_reg;
    word_t     wdata;
    word_t     rd_val;
    logic      unused_bits;

    assign a_port = addr[4:3];
    assign a_reg  = gpio_reg_e'(addr[2:0]);
    assign wdata  = wd[WIDTH-1:0];

    for (genvar g = 0; g < PORTS; g++) begin : g_port
        gpio_sync #(.WIDTH(WIDTH)) u_sync (
            .clk    (clk),
            .resetq (resetq),
            .pin    (pin_in[g*WIDTH +: WIDTH]),
            .sync   (in_s[g]),
            .rise   (rise_s[g])
        );
        assign pin_out[g*WIDTH +: WIDTH] = out_r[g];
        assign pin_oe[g*WIDTH +: WIDTH]  = dir_r[g];
    end

    // Port indices >= PORTS never match a loop index, so they are ignored here.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                out_r[i] <= '0;
                dir_r[i] <= '0;
            end
        end else if (io_wr) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (a_port == 2'(i)) begin
                    case (a_reg)
                        REG_OUT: out_r[i] <= wdata;
                        REG_DIR: dir_r[i] <= wdata;
                        REG_SET: out_r[i] <= out_r[i] | wdata;
                        REG_CLR: out_r[i] <= out_r[i] & ~wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef GPIO_BANK_IRQ_EN
    word_t edge_r [PORTS];
    word_t mask_r [PORTS];
    logic  irq_any;

    always_comb begin
        irq_any = 1'b0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            irq_any = irq_any | (|(edge_r[i] & mask_r[i]));
        end
    end

    // A fresh rise is OR-ed in after the clear so it survives a coincident W1C.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                edge_r[i] <= '0;
                mask_r[i] <= '0;
            end
            irq <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (io_wr && a_port == 2'(i) && a_reg == REG_EDGE)
                    edge_r[i] <= (edge_r[i] & ~wdata) | rise_s[i];
                else
                    edge_r[i] <= edge_r[i] | rise_s[i];
                if (io_wr && a_port == 2'(i) && a_reg == REG_MASK)
                    mask_r[i] <= wdata;
            end
            irq <= irq_any;
        end
    end

    always_comb begin
        unused_bits = ^wd;
    end
`else
    assign irq = 1'b0;

    always_comb begin
        unused_bits = ^wd;
        for (int unsigned i = 0; i < PORTS; i++) begin
            unused_bits = unused_bits ^ (^rise_s[i]);
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (a_port == 2'(i)) begin
                case (a_reg)
                    REG_OUT:  rd_val = out_r[i];
                    REG_DIR:  rd_val = dir_r[i];
                    REG_IN:   rd_val = in_s[i];
`ifdef GPIO_BANK_IRQ_EN
                    REG_EDGE: rd_val = edge_r[i];
                    REG_MASK: rd_val = mask_r[i];
`endif
                    default:  rd_val = '0;
                endcase
            end
        end
    end

    // Register state is sampled pre-edge, so a same-cycle write returns the old value.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            rd <= '0;
        else if (io_rd)
            rd <= BUS_W'(rd_val);
    end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per port (1..16).
REQ-002 SHALL have parameter PORTS, default 3, number of ports (1..4).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port resetq, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port io_wr, input, 1, one-cycle write strobe.
REQ-006 SHALL have port io_rd, input, 1, one-cycle read strobe.
REQ-007 SHALL have port addr, input, 5, {port[4:3], reg[2:0]}.
REQ-008 SHALL have port wd, input, 16, write data; bits above WIDTH ignored.
REQ-009 SHALL have port rd, output, 16, registered read data; bits above WIDTH are 0.
REQ-010 SHALL have port pin_in, input, PORTS*WIDTH, raw asynchronous pad inputs.
REQ-011 SHALL have port pin_out, output, PORTS*WIDTH, output data to pad buffers.
REQ-012 SHALL have port pin_oe, output, PORTS*WIDTH, output enable; 1 means drive.
REQ-013 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-014 SHALL implement per-port registers at reg index: 0 OUT (r/w), 1 DIR (r/w, 1=output), 2 SET (w, write-1-sets OUT bits), 3 CLR (w, write-1-clears OUT bits), 4 IN (r, synchronised pins), 5 EDGE (r, write-1-clear), 6 MASK (r/w); index 7 reserved.
REQ-015 SHALL apply writes on the io_wr cycle; new OUT/DIR visible on pin_out/pin_oe the next cycle.
REQ-016 SHALL drive pin_out directly from OUT and pin_oe directly from DIR, registered with no combinational path from the bus.
REQ-017 SHALL pass each pin_in bit through two flops before IN; IN reflects a pad change 2 cycles later.
REQ-018 SHALL set an EDGE bit when the synchronised input goes 0->1, independent of DIR.
REQ-019 SHALL keep an EDGE bit set when a write-1-clear and a new rising edge on that bit coincide.
REQ-020 SHALL drive irq high the cycle after any (EDGE & MASK) bit is nonzero in any port, low the cycle after none is.
REQ-021 SHALL update rd one cycle after io_rd and hold it until the next io_rd.
REQ-022 SHALL return 0 from reads of SET, CLR, reserved index 7, and port indices >= PORTS.
REQ-023 SHALL ignore writes to IN, reserved index 7, and port indices >= PORTS.
REQ-024 SHALL, when io_rd and io_wr coincide at the same address, return the pre-write value.

Reset
REQ-025 SHALL, on resetq low, clear OUT, DIR (all inputs), EDGE, MASK, synchroniser flops, rd and irq to 0 immediately.
REQ-026 SHALL not set EDGE bits in the first 2 cycles after reset release, whatever the pin levels.

Configuration
REQ-027 SHALL compile EDGE, MASK, edge detection and irq logic only when GPIO_BANK_IRQ_EN is defined.
REQ-028 SHALL, without GPIO_BANK_IRQ_EN, read EDGE and MASK as 0, ignore writes to them and tie irq to 0.

Structure
REQ-029 SHALL take register-index constants (OUT, DIR, SET, CLR, IN, EDGE, MASK) from the shared package gpio_pkg.
REQ-030 SHALL use one sub-module, gpio_sync (WIDTH-bit two-flop synchroniser plus rising-edge pulse), instantiated once per port.

Verification
REQ-031 SHALL check: write OUT p0=0xA5 then DIR p0=0xFF -> pin_out[7:0]=0xA5, pin_oe[7:0]=0xFF one cycle after each write.
REQ-032 SHALL check: OUT p1=0x0F, SET p1=0x30, CLR p1=0x01 -> read OUT p1 = 0x3E.
REQ-033 SHALL check: pin_in[23:16] 0x00->0x81 -> read IN p2 = 0x81 after 2 cycles, EDGE p2 = 0x81.
REQ-034 SHALL check: MASK p2=0x01, with EDGE p2 bit0 set -> irq=1; write EDGE p2=0x01 -> irq=0; W1C coinciding with a new edge -> bit stays set, irq stays 1.
REQ-035 SHALL check: read port 3 with PORTS=3 -> rd=0x0000; write there -> no register changes.
REQ-036 SHALL check: assert resetq mid-operation with OUT=0xFF, DIR=0xFF -> pin_out, pin_oe, irq = 0 without waiting for a clk edge.
